// File: rtl/hms_time_core_if.sv
// Control/status bundle between the controller, hms_time_core and the display scan path.
interface hms_time_core_if;
  logic [1:0] i_mode;
  logic [1:0] i_sel;
  logic       i_inc;
  logic       i_alarm_en;
  logic       i_ack;
  logic       i_snooze;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic [5:0] o_disp_sec;
  logic [5:0] o_disp_min;
  logic [4:0] o_disp_hour;
  logic       o_tick;
  logic       o_alarm;

  modport master (
    output i_mode, i_sel, i_inc, i_alarm_en, i_ack, i_snooze,
    input  o_sec, o_min, o_hour, o_disp_sec, o_disp_min, o_disp_hour, o_tick, o_alarm
  );

  modport slave (
    input  i_mode, i_sel, i_inc, i_alarm_en, i_ack, i_snooze,
    output o_sec, o_min, o_hour, o_disp_sec, o_disp_min, o_disp_hour, o_tick, o_alarm
  );
endinterface

// File: rtl/hms_time_core.sv
// Single-clock hh:mm:ss timekeeper with set modes, alarm register and alarm latch.
// Optional snooze countdown is built only when HMS_SNOOZE_EN is defined.
module hms_time_core #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned HOUR_MAX   = 23,
  parameter int unsigned SNOOZE_SEC = 300
) (
  input logic           clk,
  input logic           rst_n,
  hms_time_core_if.slave bus
);

  typedef enum logic [1:0] {
    M_RUN       = 2'b00,
    M_SET_TIME  = 2'b01,
    M_SET_ALARM = 2'b10,
    M_RUN_ALT   = 2'b11
  } mode_e;

  localparam int unsigned CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [4:0]  HMAX = 5'(HOUR_MAX);

  mode_e       mode;
  logic        set_time;
  logic        set_alarm;
  logic        adv;
  logic        match;
  logic [CW-1:0] cnt;
  logic [5:0]  sec, min, al_sec, al_min;
  logic [4:0]  hour, al_hour;
  logic        tick;
  logic        alarm, alarm_n;

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? '0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc_hr(input logic [4:0] v);
    return (v == HMAX) ? '0 : v + 5'd1;
  endfunction

  assign mode      = mode_e'(bus.i_mode);
  assign set_time  = (mode == M_SET_TIME);
  assign set_alarm = (mode == M_SET_ALARM);
  assign adv       = !set_time && (cnt == CW'(TICK_DIV - 1));
  assign match     = (sec == al_sec) && (min == al_min) && (hour == al_hour);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      tick    <= 1'b0;
      sec     <= '0;
      min     <= '0;
      hour    <= '0;
      al_sec  <= '0;
      al_min  <= '0;
      al_hour <= '0;
    end else begin
      if (set_time || adv) cnt <= '0;
      else                 cnt <= cnt + CW'(1);
      tick <= adv;

      // Tick carry and live-field editing are exclusive: no ticks in SET_TIME.
      if (adv) begin
        sec <= inc60(sec);
        if (sec == 6'd59) begin
          min <= inc60(min);
          if (min == 6'd59) hour <= inc_hr(hour);
        end
      end else if (set_time && bus.i_inc) begin
        case (bus.i_sel)
          2'd0:    sec  <= inc60(sec);
          2'd1:    min  <= inc60(min);
          2'd2:    hour <= inc_hr(hour);
          default: ;
        endcase
      end

      if (set_alarm && bus.i_inc) begin
        case (bus.i_sel)
          2'd0:    al_sec  <= inc60(al_sec);
          2'd1:    al_min  <= inc60(al_min);
          2'd2:    al_hour <= inc_hr(al_hour);
          default: ;
        endcase
      end
    end
  end

`ifdef HMS_SNOOZE_EN
  localparam int unsigned SW = (SNOOZE_SEC > 0) ? $clog2(SNOOZE_SEC + 1) : 1;

  logic [SW-1:0] snz, snz_n;
  logic          pend, pend_n;

  // Later assignments take priority: match beats ack, disarm beats everything.
  always_comb begin
    alarm_n = alarm;
    pend_n  = pend;
    snz_n   = snz;
    if (tick && pend) begin
      if (snz <= SW'(1)) begin
        pend_n  = 1'b0;
        snz_n   = '0;
        alarm_n = 1'b1;
      end else begin
        snz_n = snz - SW'(1);
      end
    end
    if (bus.i_ack) begin
      alarm_n = 1'b0;
      pend_n  = 1'b0;
    end
    if (bus.i_snooze && alarm) begin
      alarm_n = 1'b0;
      pend_n  = 1'b1;
      snz_n   = SW'(SNOOZE_SEC);
    end
    if (tick && match) alarm_n = 1'b1;
    if (!bus.i_alarm_en) begin
      alarm_n = 1'b0;
      pend_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm <= 1'b0;
      pend  <= 1'b0;
      snz   <= '0;
    end else begin
      alarm <= alarm_n;
      pend  <= pend_n;
      snz   <= snz_n;
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = bus.i_snooze;

  always_comb begin
    alarm_n = alarm;
    if (bus.i_ack)         alarm_n = 1'b0;
    if (tick && match)     alarm_n = 1'b1;
    if (!bus.i_alarm_en)   alarm_n = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alarm <= 1'b0;
    else        alarm <= alarm_n;
  end
`endif

  assign bus.o_sec       = sec;
  assign bus.o_min       = min;
  assign bus.o_hour      = hour;
  assign bus.o_disp_sec  = set_alarm ? al_sec  : sec;
  assign bus.o_disp_min  = set_alarm ? al_min  : min;
  assign bus.o_disp_hour = set_alarm ? al_hour : hour;
  assign bus.o_tick      = tick;
  assign bus.o_alarm     = alarm;

endmodule
